sram_req_master: RTL

//   Initiator side of the sram_if_t link. Converts a valid/ready request stream
//   (read or write) into single-cycle SRAM accesses, then returns read data on a

---
 rtl/sram_req_master_if.sv | 26 ++
 rtl/sram_req_master.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sram_req_master_if.sv
// sram_if_t: single-port synchronous SRAM link.
// The master drives address, write enable and write data every cycle; the
// slave returns read data one clock after the address was presented.
interface sram_if_t #(
   parameter int unsigned AW = 15,
   parameter int unsigned DW = 32
);
   logic [AW-1:0] addr;
   logic          wen;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport master (
      output addr,
      output wen,
      output wdata,
      input  rdata
   );

   modport slave (
      input  addr,
      input  wen,
      input  wdata,
      output rdata
   );
endinterface

// File: rtl/sram_req_master.sv
// sram_req_master: initiator side of an sram_if_t link.
// Turns a valid/ready request stream into single-cycle SRAM accesses and
// returns read data, in request order, on a valid/ready response stream.
// Writes are posted. A small response FIFO plus a credit rule absorbs the
// one-cycle SRAM read latency so a stalled consumer never loses data.

// Invariant checker for the response path, kept apart from the datapath.
module sram_req_master_chk #(
   parameter int unsigned RSP_DEPTH = 2,
   parameter int unsigned CW        = 2
) (
   input logic          clk,
   input logic          rst_n,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] cnt
);
   localparam logic [CW-1:0] CNT_FULL = RSP_DEPTH[CW-1:0];

   // A push into a full FIFO without a simultaneous pop would drop read data.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (cnt == CNT_FULL)))
      else $error("sram_req_master: response FIFO overflow");

   // The occupancy counter must stay within the FIFO capacity.
   a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
      (cnt <= CNT_FULL))
      else $error("sram_req_master: response FIFO count out of range");
endmodule

module sram_req_master #(
   parameter int unsigned AW        = 15,
   parameter int unsigned DW        = 32,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_vld,
   output logic          req_rdy,
   input  logic          req_wen,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [DW-1:0] rsp_rdata,
   sram_if_t.master      sram_rw
);
   // Pointer width (at least one bit) and counter width covering 0..RSP_DEPTH.
   localparam int unsigned PW      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CW      = $clog2(RSP_DEPTH + 1);
   localparam int unsigned LAST_I  = RSP_DEPTH - 1;
   localparam logic [PW-1:0] PTR_LAST = LAST_I[PW-1:0];
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW:0]   OCC_CAP  = RSP_DEPTH[CW:0];

   // Circular pointer advance, wrapping at RSP_DEPTH (not a power of two in general).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PTR_LAST) begin
         r = '0;
      end else begin
         r = p + PTR_ONE;
      end
      return r;
   endfunction

   // State
   logic                          rd_pend_q,   rd_pend_d;
   logic [CW-1:0]                 cnt_q,       cnt_d;
   logic [PW-1:0]                 rd_ptr_q,    rd_ptr_d;
   logic [PW-1:0]                 wr_ptr_q,    wr_ptr_d;
   logic [RSP_DEPTH-1:0][DW-1:0]  fifo_mem_q,  fifo_mem_d;
   logic                          rsp_vld_q,   rsp_vld_d;
   logic [DW-1:0]                 rsp_rdata_q, rsp_rdata_d;

   // Handshake helpers
   logic          acc;
   logic          pop;
   logic          push;
   logic [CW:0]   occ;

   // Credit check: reads in flight plus buffered responses, less the one
   // leaving this cycle, must leave room for one more read.
   always_comb begin
      pop     = rsp_vld_q & rsp_rdy;
      push    = rd_pend_q;
      occ     = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};
      req_rdy = ((occ - {{CW{1'b0}}, pop}) < OCC_CAP);
      acc     = req_vld & req_rdy;
   end

   // SRAM is driven straight from the request; idle cycles are harmless reads.
   assign sram_rw.addr  = req_addr;
   assign sram_rw.wdata = req_wdata;
   assign sram_rw.wen   = acc & req_wen;

   // Next-state for the read tracker, FIFO storage, pointers and count.
   always_comb begin
      rd_pend_d  = acc & ~req_wen;
      fifo_mem_d = fifo_mem_q;

      if (push) begin
         fifo_mem_d[wr_ptr_q] = sram_rw.rdata;
         wr_ptr_d             = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // Registered response outputs: the head is taken from the post-update
   // storage so a push into an empty FIFO is visible next cycle, and the last
   // value is held once the FIFO drains.
   always_comb begin
      rsp_vld_d = (cnt_d != '0);
      if (cnt_d != '0) begin
         rsp_rdata_d = fifo_mem_d[rd_ptr_d];
      end else begin
         rsp_rdata_d = rsp_rdata_q;
      end
   end

   // State registers; reset drops in-flight reads and buffered responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_q   <= 1'b0;
         cnt_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         fifo_mem_q  <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rd_pend_q   <= rd_pend_d;
         cnt_q       <= cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         fifo_mem_q  <= fifo_mem_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = rsp_rdata_q;

   sram_req_master_chk #(
      .RSP_DEPTH (RSP_DEPTH),
      .CW        (CW)
   ) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .cnt   (cnt_q)
   );
endmodule
